// File: rtl/pipe_stage_skid_reg_pkg.sv
// rtl/pipe_stage_skid_reg_pkg.sv - default widths and ctrl/data field layout shared by ID and EXE
package pipe_stage_skid_reg_pkg;

    localparam int CTRL_W_DEF = 12;
    localparam int DATA_W_DEF = 136;

    localparam int CTRL_WB_EN       = 0;
    localparam int CTRL_MEM_R_EN    = 1;
    localparam int CTRL_MEM_W_EN    = 2;
    localparam int CTRL_EXE_CMD_LSB = 3;
    localparam int EXE_CMD_W        = 4;
    localparam int CTRL_B           = 7;
    localparam int CTRL_S           = 8;
    localparam int CTRL_IMM         = 9;

    // The shift operand is the low 12 bits of imm24, so it has no field of its own.
    localparam int DATA_PC_LSB     = 0;
    localparam int DATA_VAL_RN_LSB = 32;
    localparam int DATA_VAL_RM_LSB = 64;
    localparam int DATA_IMM24_LSB  = 96;
    localparam int DATA_DEST_LSB   = 120;
    localparam int DATA_SRC_1_LSB  = 124;
    localparam int DATA_SRC_2_LSB  = 128;
    localparam int DATA_SR_LSB     = 132;
    localparam int REG_ID_W        = 4;

    typedef logic [REG_ID_W-1:0]  reg_id_t;
    typedef logic [EXE_CMD_W-1:0] exe_cmd_t;

    function automatic exe_cmd_t get_exe_cmd(input logic [CTRL_W_DEF-1:0] ctrl);
        return ctrl[CTRL_EXE_CMD_LSB +: EXE_CMD_W];
    endfunction

    function automatic reg_id_t get_dest(input logic [DATA_W_DEF-1:0] data);
        return data[DATA_DEST_LSB +: REG_ID_W];
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+ctrl+data register with load, drain and flush clear
module pipe_entry_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drain,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Drain empties the entry but keeps data; only reset/flush may zero it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA != 0) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end else if (drain) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - handshaked inter-stage register with optional 2-entry skid buffer
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              freeze,
    output logic [1:0]        occupancy
);

    logic              take;
    logic              acc;
    logic              main_free;
    logic              main_load;
    logic              main_drain;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    assign take      = out_valid & out_ready & ~freeze & ~flush;
    assign acc       = in_valid & in_ready;
    assign main_free = ~out_valid | take;

    // A waiting skid entry always goes ahead of new input to keep FIFO order.
    assign main_load   = ~freeze & main_free & (skid_valid | acc);
    assign main_drain  = ~freeze & main_free & ~skid_valid & ~acc;
    assign main_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
    assign main_data_d = skid_valid ? skid_data : in_data;

    pipe_entry_reg #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (main_load),
        .drain  (main_drain),
        .d_ctrl (main_ctrl_d),
        .d_data (main_data_d),
        .valid  (out_valid),
        .ctrl   (out_ctrl),
        .data   (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load;
            logic skid_drain;

            // in_ready comes from the skid flop, not from out_ready.
            assign in_ready   = ~rst & ~skid_valid & ~freeze & ~flush;
            assign skid_load  = ~freeze & ~main_free & acc;
            assign skid_drain = ~freeze & main_free & skid_valid;

            pipe_entry_reg #(
                .CTRL_W     (CTRL_W),
                .DATA_W     (DATA_W),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .clear  (flush),
                .load   (skid_load),
                .drain  (skid_drain),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (skid_valid),
                .ctrl   (skid_ctrl),
                .data   (skid_data)
            );
        end else begin : g_no_skid
            assign in_ready   = ~rst & ~freeze & ~flush & (~out_valid | out_ready);
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - bench for pipe_stage_skid_reg (SKID=1/CLEAR_DATA=1 and SKID=0/CLEAR_DATA=0)
module tb_pipe_stage_skid_reg;

    localparam int CW = 12;
    localparam int DW = 136;
    localparam bit H  = 1'b1;
    localparam bit L  = 1'b0;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, flush, freeze;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .flush(flush), .freeze(freeze), .occupancy(occ1));

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .flush(flush), .freeze(freeze), .occupancy(occ0));

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        bit            rst;
        bit            iv;
        logic [CW-1:0] ctrl;
        bit            ordy;
        bit            fz;
        bit            ir;
        bit            ov;
        logic [CW-1:0] octl;
        logic [1:0]    occ;
    } vec_t;

    // Reference: each stage is a bounded FIFO; the head is what the output shows.
    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] hold1, hold0;
    bit            hk0 = 1'b0;
    vec_t          tbl[$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
        return {c, 8'hA5, ~c, {8{c, 1'b1}}};
    endfunction

    function automatic vec_t v(bit r, bit iv, logic [CW-1:0] c, bit ordy, bit fz,
                               bit ir, bit ov, logic [CW-1:0] oc, logic [1:0] occ);
        vec_t t;
        t.rst = r; t.iv = iv; t.ctrl = c; t.ordy = ordy; t.fz = fz;
        t.ir = ir; t.ov = ov; t.octl = oc; t.occ = occ;
        return t;
    endfunction

    function automatic bit exp_ir(input int n, input bit skid);
        if (rst || flush || freeze) return 1'b0;
        if (skid) return n < 2;
        return (n == 0) || out_ready;
    endfunction

    task automatic set_in(input bit r, input bit iv, input logic [CW-1:0] c,
                          input bit ordy, input bit fl, input bit fz);
        rst = r; in_valid = iv; in_ctrl = c; in_data = mk_data(c);
        out_ready = ordy; flush = fl; freeze = fz;
    endtask

    // Called with clk low; checks in_ready before the edge, outputs after it.
    task automatic step();
        bit   ir1e, ir0e;
        ent_t e;
        #1;
        ir1e = exp_ir(q1.size(), 1'b1);
        ir0e = exp_ir(q0.size(), 1'b0);
        chk("m_in_ready1", DW'(in_ready1), DW'(ir1e));
        chk("m_in_ready0", DW'(in_ready0), DW'(ir0e));
        @(posedge clk);
        e = '{ctrl: in_ctrl, data: in_data};
        if (rst || flush) begin
            q1.delete();
            hold1 = '0;
            if (q0.size() > 0) begin
                hold0 = q0[0].data;
                hk0   = 1'b1;
            end
            q0.delete();
        end else if (!freeze) begin
            if (q1.size() > 0 && out_ready) begin
                hold1 = q1[0].data;
                void'(q1.pop_front());
            end
            if (in_valid && ir1e) q1.push_back(e);
            if (q0.size() > 0 && out_ready) begin
                hold0 = q0[0].data;
                hk0   = 1'b1;
                void'(q0.pop_front());
            end
            if (in_valid && ir0e) q0.push_back(e);
        end
        #1;
        chk("m_out_valid1", DW'(out_valid1), DW'(q1.size() > 0));
        chk("m_out_ctrl1", DW'(out_ctrl1), DW'(q1.size() > 0 ? q1[0].ctrl : '0));
        chk("m_occ1", DW'(occ1), DW'(q1.size()));
        chk("m_out_data1", out_data1, q1.size() > 0 ? q1[0].data : hold1);
        chk("m_out_valid0", DW'(out_valid0), DW'(q0.size() > 0));
        chk("m_out_ctrl0", DW'(out_ctrl0), DW'(q0.size() > 0 ? q0[0].ctrl : '0));
        chk("m_occ0", DW'(occ0), DW'(q0.size()));
        if (q0.size() > 0 || hk0)
            chk("m_out_data0", out_data0, q0.size() > 0 ? q0[0].data : hold0);
        @(negedge clk);
    endtask

    initial begin
        logic [159:0] rnd;

        tbl.push_back(v(H, H, 12'hFFF, L, L, L, L, 12'h000, 2'd0));
        tbl.push_back(v(H, H, 12'hFFF, L, L, L, L, 12'h000, 2'd0));
        tbl.push_back(v(L, L, 12'h000, H, L, H, L, 12'h000, 2'd0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(v(L, H, 12'(k), H, L, H, H, 12'(k), 2'd1));
        tbl.push_back(v(L, L, 12'h000, H, L, H, L, 12'h000, 2'd0));
        tbl.push_back(v(L, H, 12'h00A, L, L, H, H, 12'h00A, 2'd1));
        tbl.push_back(v(L, H, 12'h00B, L, L, H, H, 12'h00A, 2'd2));
        tbl.push_back(v(L, H, 12'h00C, L, L, L, H, 12'h00A, 2'd2));
        tbl.push_back(v(L, H, 12'h00C, H, L, L, H, 12'h00B, 2'd1));
        tbl.push_back(v(L, H, 12'h00C, H, L, H, H, 12'h00C, 2'd1));
        tbl.push_back(v(L, L, 12'h000, H, L, H, L, 12'h000, 2'd0));
        tbl.push_back(v(L, H, 12'h00A, L, L, H, H, 12'h00A, 2'd1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(L, H, 12'h005, H, H, L, H, 12'h00A, 2'd1));
        tbl.push_back(v(L, H, 12'h005, H, L, H, H, 12'h005, 2'd1));
        tbl.push_back(v(L, L, 12'h000, H, L, H, L, 12'h000, 2'd0));

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].iv, tbl[i].ctrl, tbl[i].ordy, L, tbl[i].fz);
            #1;
            chk($sformatf("t%0d_in_ready", i), DW'(in_ready1), DW'(tbl[i].ir));
            step();
            chk($sformatf("t%0d_out_valid", i), DW'(out_valid1), DW'(tbl[i].ov));
            chk($sformatf("t%0d_out_ctrl", i), DW'(out_ctrl1), DW'(tbl[i].octl));
            chk($sformatf("t%0d_occ", i), DW'(occ1), DW'(tbl[i].occ));
        end

        // Flush wins over freeze and a same-cycle input while both entries are full.
        set_in(L, H, 12'h011, L, L, L); step();
        set_in(L, H, 12'h022, L, L, L); step();
        chk("fl_occ_full", DW'(occ1), DW'(2'd2));
        set_in(L, H, 12'h033, H, H, H);
        #1;
        chk("fl_in_ready", DW'(in_ready1), DW'(1'b0));
        step();
        chk("fl_out_valid", DW'(out_valid1), DW'(1'b0));
        chk("fl_out_ctrl", DW'(out_ctrl1), DW'(12'h000));
        chk("fl_occ", DW'(occ1), DW'(2'd0));
        chk("fl_data_clear", out_data1, '0);
        chk("fl_data_hold", out_data0, mk_data(12'h011));
        chk("fl_out_valid0", DW'(out_valid0), DW'(1'b0));
        set_in(L, L, 12'h000, L, L, L); step();
        chk("fl_discard", DW'(occ1), DW'(2'd0));

        // Single-entry build: ready follows out_ready in the same cycle.
        set_in(L, H, 12'h040, L, L, L); step();
        set_in(L, H, 12'h041, L, L, L);
        #1;
        chk("s0_ir_full", DW'(in_ready0), DW'(1'b0));
        step();
        set_in(L, H, 12'h041, H, L, L);
        #1;
        chk("s0_ir_take", DW'(in_ready0), DW'(1'b1));
        step();
        chk("s0_ctrl_41", DW'(out_ctrl0), DW'(12'h041));
        chk("s0_occ_41", DW'(occ0), DW'(2'd1));
        set_in(L, H, 12'h042, H, L, L); step();
        chk("s0_ctrl_42", DW'(out_ctrl0), DW'(12'h042));
        chk("s0_occ_42", DW'(occ0), DW'(2'd1));

        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(59) == 0);
            flush     = ($urandom_range(24) == 0);
            freeze    = ($urandom_range(7) == 0);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            in_ctrl   = CW'($urandom);
            rnd       = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_data   = rnd[DW-1:0];
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, handshaked successor to the fixed-field inter-stage pipeline registers (ID/EX and similar).
- Carries an opaque control vector and data vector between two pipeline stages using valid/ready.
- Optional 2-entry skid buffer decouples the ready path, so upstream in_ready never depends combinationally on out_ready.
- Keeps the existing stage-register semantics: flush kills the stage (control zeroed) and freeze holds the stage.

Parameters:
- CTRL_W, 12, width of the control vector (wb_en, mem_r_en, mem_w_en, exe_cmd, b, s, imm, ...). All control bits are zeroed on reset and flush.
- DATA_W, 136, width of the data vector (pc, operands, shift operand, imm24, dest, src ids, sr).
- SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- CLEAR_DATA, 1, 1 = data vector zeroed on reset/flush; 0 = data holds its previous value (saves area).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage accepts an entry this cycle
- in_ctrl  in  CTRL_W  control vector
- in_data  in  DATA_W  data vector
- out_valid  out  1  stage holds a valid entry
- out_ready  in  1  downstream takes the entry
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
- out_data  out  DATA_W  registered data
- flush  in  1  kill all entries (branch taken in EXE)
- freeze  in  1  hold all state (hazard stall)
- occupancy  out  2  number of valid entries, 0..2 (max 1 when SKID=0)

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst as in the rest of the codebase.
- Priority, evaluated per rising edge: rst > flush > freeze > normal.
- Reset/flush:
  - out_valid=0, skid_valid=0, out_ctrl=0, skid ctrl=0, occupancy=0.
  - Data is zeroed when CLEAR_DATA=1, otherwise held.
  - An input presented in the same cycle is discarded.
  - in_ready=0 combinationally while rst or flush is high.
- Freeze:
  - No register changes.
  - in_ready=0.
  - out_ready is ignored; no downstream transfer is counted.
- Handshake definitions:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready & !freeze & !flush.
- SKID=1:
  - in_ready = !skid_valid & !freeze & !flush.
  - Main empty or take:
    - main <= skid if skid_valid (skid_valid<=0; a simultaneous acc is impossible because in_ready=0).
    - else main <= input if acc.
    - else out_valid<=0 and out_ctrl<=0.
  - Main full, no take, acc: skid <= input, skid_valid<=1.
  - Ordering is strictly FIFO; no entry is dropped or duplicated.
- SKID=0:
  - in_ready = !freeze & !flush & (!out_valid | out_ready).
  - acc loads main; take without acc clears out_valid and out_ctrl.
- Latency: 1 cycle from acc to out_valid when the stage is empty. Throughput: 1 entry/cycle sustained with out_ready=1.
- occupancy = out_valid + skid_valid, registered, consistent with both valid bits every cycle.
- Invariant: skid_valid=1 implies out_valid=1.
- Upstream rule: in_ctrl/in_data need only be stable in the acc cycle.

Decomposition:
- Shared pkg: CTRL_W/DATA_W defaults and field offset constants (exe_cmd, dest, src_1, src_2 positions) for pack/unpack by the ID and EXE stages.
- One sub-module, pipe_entry_reg: a single valid+ctrl+data register with load/clear enables and CLEAR_DATA handling. Instantiated as main, plus skid when SKID=1.

Test Plan:
- Reset/flush values: rst=1 for 2 cycles with in_valid=1, in_ctrl=12'hFFF → out_valid=0, out_ctrl=0, occupancy=0, in_ready=0; after release, in_ready=1.
- Streaming: out_ready=1, push ctrl 1..8 on consecutive cycles → out_ctrl 1..8 appear one cycle later, back-to-back, occupancy stays 1.
- Backpressure, SKID=1:
  - Push A,B,C with out_ready=0.
  - After A,B: occupancy=2, in_ready=0, C held upstream.
  - Raise out_ready → output sequence A,B,C in order, no loss or duplication.
- Freeze: with A held, freeze=1 for 3 cycles while out_ready=1 and in_valid=1 → out_ctrl stays A, in_ready=0, occupancy unchanged; freeze=0 resumes normally.
- Flush with simultaneous events: occupancy=2, then flush=1 with in_valid=1 and freeze=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, incoming entry discarded; data=0 with CLEAR_DATA=1, unchanged with CLEAR_DATA=0.
- SKID=0 build: out_ready=0 with a full stage → in_ready=0 in the same cycle; out_ready=1 with in_valid=1 → take and accept in one cycle, occupancy stays 1.
